// File: rtl/tracker_pkg.sv
// Shared types and defaults for the activity tracker: FSM state encoding,
// MODE encodings and the default parameter values used by the top and rate generator.
package tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam logic [1:0] MODE_EXT  = 2'b00;
  localparam logic [1:0] MODE_WALK = 2'b01;
  localparam logic [1:0] MODE_JOG  = 2'b10;
  localparam logic [1:0] MODE_RUN  = 2'b11;

  localparam int DEF_STEP_W     = 14;
  localparam int DEF_MAX_STEPS  = 9999;
  localparam int DEF_DIST_SHIFT = 5;
  localparam int DEF_TICK_DIV   = 100;
  localparam int DEF_P_WALK     = 128;
  localparam int DEF_P_JOG      = 64;
  localparam int DEF_P_RUN      = 32;
  localparam int DEF_WIN_TICKS  = 1000;
  localparam int DEF_HI_THRESH  = 20;

endpackage

// File: rtl/tracker_rate_gen.sv
// Base-tick prescaler and per-mode period counter; emits one internal step
// pulse every (TICK_DIV * period) running cycles.
module tracker_rate_gen
  import tracker_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int P_WALK   = DEF_P_WALK,
  parameter int P_JOG    = DEF_P_JOG,
  parameter int P_RUN    = DEF_P_RUN
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       run,
  input  logic       clear,
  input  logic [1:0] mode,
  output logic       tick,
  output logic       step
);

  localparam int PRE_W   = $clog2(TICK_DIV + 1);
  localparam int PER_MAX = (P_WALK > P_JOG) ? ((P_WALK > P_RUN) ? P_WALK : P_RUN)
                                            : ((P_JOG > P_RUN) ? P_JOG : P_RUN);
  localparam int PER_W   = $clog2(PER_MAX + 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [PER_W-1:0] per_cnt;
  logic [PER_W-1:0] period_m1;

  always_comb begin
    period_m1 = '0;
    case (mode)
      MODE_WALK: period_m1 = PER_W'(P_WALK - 1);
      MODE_JOG:  period_m1 = PER_W'(P_JOG - 1);
      MODE_RUN:  period_m1 = PER_W'(P_RUN - 1);
      default:   period_m1 = '0;
    endcase
  end

  // clear covers IDLE, CLR and a mode change, so no tick leaks out on those cycles
  assign tick = run && !clear && (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign step = tick && (mode != MODE_EXT) && (per_cnt == period_m1);

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      pre_cnt <= '0;
      per_cnt <= '0;
    end else if (run) begin
      if (tick) begin
        pre_cnt <= '0;
        per_cnt <= (per_cnt == period_m1) ? '0 : per_cnt + PER_W'(1);
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/activity_tracker.sv
// Step counter with IDLE/RUN/PAUSED control, internal cadence or external sensor steps.
// Define TRACKER_HIACT_EN to build the high-activity window counter (HIACT_CNT).
module activity_tracker
  import tracker_pkg::*;
#(
  parameter int STEP_W     = DEF_STEP_W,
  parameter int MAX_STEPS  = DEF_MAX_STEPS,
  parameter int DIST_SHIFT = DEF_DIST_SHIFT,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int P_WALK     = DEF_P_WALK,
  parameter int P_JOG      = DEF_P_JOG,
  parameter int P_RUN      = DEF_P_RUN,
  parameter int WIN_TICKS  = DEF_WIN_TICKS,
  parameter int HI_THRESH  = DEF_HI_THRESH
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       START,
  input  logic                       STOP,
  input  logic                       CLR,
  input  logic [1:0]                 MODE,
  input  logic                       EXT_PULSE,
  output logic [STEP_W-1:0]          STEPS,
  output logic [STEP_W-DIST_SHIFT-1:0] DISTANCE,
  output logic                       OFLOW,
  output logic                       RUNNING,
  output logic                       STEP_STROBE,
  output logic [7:0]                 HIACT_CNT
);

  if (MAX_STEPS >= 2**STEP_W || DIST_SHIFT >= STEP_W || TICK_DIV < 1 ||
      WIN_TICKS < 1 || HI_THRESH < 0) begin : g_cfg_check
    $error("activity_tracker: illegal parameter set");
  end

  function automatic logic [STEP_W-1:0] sat_step(input logic [STEP_W-1:0] v);
    return (v >= STEP_W'(MAX_STEPS)) ? STEP_W'(MAX_STEPS) : v + STEP_W'(1);
  endfunction

  state_t     state, state_nxt;
  logic [1:0] mode_q;
  logic       ext_q;
  logic       run, mode_chg, rg_clear;
  logic       tick, rg_step, ext_edge;
  logic       step_p0, at_max;

  assign run      = (state == ST_RUN);
  assign mode_chg = (MODE != mode_q);
  assign rg_clear = (state == ST_IDLE) || CLR || mode_chg;
  assign RUNNING  = run;

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // STOP dominates START; CLR dominates everything
  always_comb begin
    state_nxt = state;
    if (CLR) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_PAUSED: if (START && !STOP) state_nxt = ST_RUN;
        ST_RUN:             if (STOP)           state_nxt = ST_PAUSED;
        default:            state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_q <= MODE_EXT;
      ext_q  <= 1'b0;
    end else begin
      mode_q <= MODE;
      ext_q  <= EXT_PULSE;
    end
  end

  tracker_rate_gen #(
    .TICK_DIV (TICK_DIV),
    .P_WALK   (P_WALK),
    .P_JOG    (P_JOG),
    .P_RUN    (P_RUN)
  ) u_rate (
    .CLK   (CLK),
    .RESET (RESET),
    .run   (run),
    .clear (rg_clear),
    .mode  (MODE),
    .tick  (tick),
    .step  (rg_step)
  );

  // Stage p0: step event, from the sensor edge or the internal cadence
  assign ext_edge = EXT_PULSE && !ext_q;
  assign step_p0  = run && !mode_chg && ((MODE == MODE_EXT) ? ext_edge : rg_step);
  assign at_max   = (STEPS >= STEP_W'(MAX_STEPS));

  // Stage p1: registered count, strobe and sticky overflow
  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      STEPS       <= '0;
      OFLOW       <= 1'b0;
      STEP_STROBE <= 1'b0;
    end else begin
      STEP_STROBE <= step_p0 && !at_max;
      if (step_p0) begin
        if (at_max) OFLOW <= 1'b1;
        else        STEPS <= sat_step(STEPS);
      end
    end
  end

  assign DISTANCE = STEPS[STEP_W-1:DIST_SHIFT];

`ifdef TRACKER_HIACT_EN
  localparam int WT_W = $clog2(WIN_TICKS + 1);
  localparam int WS_W = $clog2(WIN_TICKS * TICK_DIV + 2);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [WT_W-1:0] win_ticks;
  logic [WS_W-1:0] win_steps;
  logic [WS_W-1:0] win_total;

  // raw step events count toward activity even once STEPS has saturated
  assign win_total = win_steps + WS_W'(step_p0);

  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      win_ticks <= '0;
      win_steps <= '0;
      HIACT_CNT <= '0;
    end else if (state == ST_IDLE) begin
      win_ticks <= '0;
      win_steps <= '0;
    end else if (tick && (win_ticks == WT_W'(WIN_TICKS - 1))) begin
      win_ticks <= '0;
      win_steps <= '0;
      if (win_total >= WS_W'(HI_THRESH)) HIACT_CNT <= sat_inc8(HIACT_CNT);
    end else begin
      if (tick) win_ticks <= win_ticks + WT_W'(1);
      win_steps <= win_total;
    end
  end
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign HIACT_CNT   = '0;
`endif

endmodule

// File: tb/tb_activity_tracker.sv
// Self-checking bench for activity_tracker: directed scenarios plus random
// control traffic, all compared against a run-cycle based reference model.
module tb_activity_tracker;

  localparam int STEP_W     = 14;
  localparam int MAX_STEPS  = 10;
  localparam int DIST_SHIFT = 5;
  localparam int TICK_DIV   = 4;
  localparam int P_WALK     = 8;
  localparam int P_JOG      = 4;
  localparam int P_RUN      = 2;
  localparam int WIN_TICKS  = 16;
  localparam int HI_THRESH  = 4;
`ifdef TRACKER_HIACT_EN
  localparam bit HIEN = 1'b1;
`else
  localparam bit HIEN = 1'b0;
`endif

  logic clk, rst, start, stop, clr, ext;
  logic [1:0] mode;
  logic [STEP_W-1:0] steps;
  logic [STEP_W-DIST_SHIFT-1:0] distance;
  logic oflow, running, strobe;
  logic [7:0] hiact;
  logic [33:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  activity_tracker #(
    .STEP_W(STEP_W), .MAX_STEPS(MAX_STEPS), .DIST_SHIFT(DIST_SHIFT),
    .TICK_DIV(TICK_DIV), .P_WALK(P_WALK), .P_JOG(P_JOG), .P_RUN(P_RUN),
    .WIN_TICKS(WIN_TICKS), .HI_THRESH(HI_THRESH)
  ) dut (
    .CLK(clk), .RESET(rst), .START(start), .STOP(stop), .CLR(clr),
    .MODE(mode), .EXT_PULSE(ext), .STEPS(steps), .DISTANCE(distance),
    .OFLOW(oflow), .RUNNING(running), .STEP_STROBE(strobe), .HIACT_CNT(hiact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {running, oflow, strobe, steps, distance, hiact};

  // ---------------- reference model ----------------
  // m_st: 0 idle, 1 run, 2 paused. m_run_cyc counts RUN cycles since the
  // cadence last restarted; steps fall on multiples of TICK_DIV*period.
  int m_st, m_run_cyc, m_steps, m_hi, m_wt, m_ws, m_evt_total;
  bit m_oflow, m_strobe, m_ext_q;
  logic [1:0] m_mode_q;

  function automatic int period_of(input logic [1:0] md);
    case (md)
      2'd1:    return P_WALK;
      2'd2:    return P_JOG;
      2'd3:    return P_RUN;
      default: return 1;
    endcase
  endfunction

  function automatic bit pred_evt();
    if (m_st != 1 || mode != m_mode_q) return 1'b0;
    if (mode == 2'd0) return ext && !m_ext_q;
    return ((m_run_cyc + 1) % (TICK_DIV * period_of(mode))) == 0;
  endfunction

  function automatic logic [33:0] exp_vec();
    logic [13:0] s;
    s = 14'(m_steps);
    return {(m_st == 1), m_oflow, m_strobe, s, 9'(s >> DIST_SHIFT), 8'(m_hi)};
  endfunction

  task automatic model_step();
    bit evt, tk, chg;
    chg = (mode != m_mode_q);
    evt = pred_evt();
    tk  = (m_st == 1) && !chg && (((m_run_cyc + 1) % TICK_DIV) == 0);
    if (rst) begin
      m_st = 0; m_run_cyc = 0; m_steps = 0; m_hi = 0; m_wt = 0; m_ws = 0;
      m_oflow = 0; m_strobe = 0; m_ext_q = 0; m_mode_q = 2'd0;
      return;
    end
    m_mode_q = mode;
    m_ext_q  = ext;
    if (clr) begin
      m_st = 0; m_run_cyc = 0; m_steps = 0; m_hi = 0; m_wt = 0; m_ws = 0;
      m_oflow = 0; m_strobe = 0;
      return;
    end
    if (evt) m_evt_total++;
    m_strobe = 1'b0;
    if (evt) begin
      if (m_steps == MAX_STEPS) m_oflow = 1'b1;
      else begin m_steps++; m_strobe = 1'b1; end
    end
    if (HIEN) begin
      if (m_st == 0) begin m_wt = 0; m_ws = 0; end
      else if (tk && m_wt == WIN_TICKS - 1) begin
        if (m_ws + int'(evt) >= HI_THRESH && m_hi < 255) m_hi++;
        m_wt = 0; m_ws = 0;
      end else begin
        if (tk) m_wt++;
        m_ws += int'(evt);
      end
    end
    if (m_st == 0 || chg) m_run_cyc = 0;
    else if (m_st == 1)   m_run_cyc++;
    case (m_st)
      0, 2:    if (start && !stop) m_st = 1;
      1:       if (stop) m_st = 2;
      default: m_st = 0;
    endcase
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; start = 0; stop = 0; clr = 0; ext = 0; mode = 2'd1;
    cyc(); cyc();
    rst = 0;
    n_checks++;
    if (obs !== 34'd0) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, 34'd0); end
    cyc();
    n_checks++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_idle: got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_walk();
    int last, nstb;
    last = -1; nstb = 0;
    mode = 2'd1; cyc();
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 330; i++) begin
      cyc();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL walk_cyc%0d: got %h want %h", i, obs, exp_vec()); end
      if (strobe === 1'b1) begin
        if (last >= 0) begin
          n_checks++;
          if (i - last != 32) begin n_fail++; $display("FAIL walk_gap: got %0d want 32", i - last); end
        end
        last = i; nstb++;
      end
    end
    n_checks++;
    if (steps !== 14'd10 || distance !== 9'd0 || nstb != 10) begin
      n_fail++; $display("FAIL walk_final: got steps=%0d dist=%0d strobes=%0d want 10/0/10", steps, distance, nstb);
    end
    clr = 1; cyc(); clr = 0;
  endtask

  task automatic test_run_sat();
    int base, nstb, k;
    nstb = 0; k = 0;
    mode = 2'd3; cyc();
    start = 1; cyc(); start = 0;
    base = m_evt_total;
    while (m_evt_total - base < 12 && k < 400) begin
      cyc(); k++;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL sat_cyc%0d: got %h want %h", k, obs, exp_vec()); end
      if (strobe === 1'b1) nstb++;
    end
    n_checks++;
    if (k >= 400) begin n_fail++; $display("FAIL sat_timeout: got %0d events want 12", m_evt_total - base); end
    n_checks++;
    if (steps !== 14'd10 || oflow !== 1'b1 || nstb != 10) begin
      n_fail++; $display("FAIL sat_final: got steps=%0d oflow=%b strobes=%0d want 10/1/10", steps, oflow, nstb);
    end
    clr = 1; cyc(); clr = 0;
    n_checks++;
    if (steps !== 14'd0 || oflow !== 1'b0 || running !== 1'b0) begin
      n_fail++; $display("FAIL sat_clr: got steps=%0d oflow=%b run=%b want 0/0/0", steps, oflow, running);
    end
  endtask

  task automatic test_ext();
    mode = 2'd0; cyc();
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 5; i++) begin
      ext = 1; cyc();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL ext_edge%0d: got %h want %h", i, obs, exp_vec()); end
      ext = 0; cyc();
    end
    cyc();
    n_checks++;
    if (steps !== 14'd5) begin n_fail++; $display("FAIL ext_count: got %0d want 5", steps); end
    stop = 1; cyc(); stop = 0;
    for (int i = 0; i < 3; i++) begin
      ext = 1; cyc(); ext = 0; cyc();
    end
    n_checks++;
    if (steps !== 14'd5 || running !== 1'b0) begin
      n_fail++; $display("FAIL ext_paused: got steps=%0d run=%b want 5/0", steps, running);
    end
  endtask

  task automatic test_start_stop();
    logic [STEP_W-1:0] s_before;
    int first;
    first = -1;
    clr = 1; cyc(); clr = 0;
    mode = 2'd1; cyc();
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL ss_run%0d: got %h want %h", i, obs, exp_vec()); end
    end
    s_before = steps;
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL ss_stop_wins: got run=%b want 0", running); end
    for (int i = 0; i < 20; i++) cyc();
    n_checks++;
    if (steps !== s_before || running !== 1'b0) begin
      n_fail++; $display("FAIL ss_pause_hold: got steps=%0d run=%b want %0d/0", steps, running, s_before);
    end
    start = 1; cyc(); start = 0;
    for (int j = 1; j <= 40; j++) begin
      cyc();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL ss_resume%0d: got %h want %h", j, obs, exp_vec()); end
      if (strobe === 1'b1 && first < 0) first = j;
    end
    // paused after 101 RUN cycles; next walk step lands on RUN cycle 128
    n_checks++;
    if (first != 27 || steps !== s_before + 1) begin
      n_fail++; $display("FAIL ss_cadence: got first=%0d steps=%0d want 27/%0d", first, steps, s_before + 1);
    end
  endtask

  task automatic test_clr_step();
    int k, seen;
    k = 0; seen = 0;
    clr = 1; cyc(); clr = 0;
    mode = 2'd3; cyc();
    start = 1; cyc(); start = 0;
    while (!(seen == 2 && pred_evt()) && k < 100) begin
      if (pred_evt()) seen++;
      cyc(); k++;
    end
    clr = 1; cyc(); clr = 0;
    n_checks++;
    if (k >= 100 || steps !== 14'd0 || strobe !== 1'b0 || running !== 1'b0) begin
      n_fail++; $display("FAIL clr_vs_step: got steps=%0d stb=%b run=%b k=%0d want 0/0/0", steps, strobe, running, k);
    end
    mode = 2'd3; start = 1; cyc(); start = 0;
    for (int i = 0; i < 5; i++) cyc();
    rst = 1;
    while (!pred_evt() && k < 200) begin rst = 0; cyc(); k++; rst = 1; end
    cyc(); rst = 0;
    n_checks++;
    if (obs !== 34'd0) begin n_fail++; $display("FAIL reset_vs_step: got %h want %h", obs, 34'd0); end
  endtask

  task automatic test_hiact();
    logic [7:0] h;
    clr = 1; cyc(); clr = 0;
    mode = 2'd2; cyc();
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 202; i++) begin
      cyc();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL hi_jog%0d: got %h want %h", i, obs, exp_vec()); end
    end
    h = HIEN ? 8'd3 : 8'd0;
    n_checks++;
    if (hiact !== h) begin n_fail++; $display("FAIL hi_jog_count: got %0d want %0d", hiact, h); end
    mode = 2'd1;
    for (int i = 0; i < 128; i++) begin
      cyc();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL hi_walk%0d: got %h want %h", i, obs, exp_vec()); end
    end
    n_checks++;
    if (hiact !== h) begin n_fail++; $display("FAIL hi_walk_count: got %0d want %0d", hiact, h); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      clr   = ($urandom_range(0, 79) == 0);
      ext   = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      cyc();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_cyc%0d: got %h want %h", i, obs, exp_vec()); end
    end
    rst = 0; start = 0; stop = 0; clr = 0; ext = 0;
  endtask

  initial begin
    m_evt_total = 0;
    test_reset();
    test_walk();
    test_run_sat();
    test_ext();
    test_start_stop();
    test_clr_step();
    test_hiact();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
